adder_arbiter: RTL

Shares one `WIDTH`-bit adder among `NREQ` requesters using round-robin arbitration.
- Each requester presents an operand pair plus carry-in with a valid/ready handshake.
- The winner's operands are captured, summed over one registered compute cycle, and returned as a tagged response with sum and zero flag.
- The block sits between the client logic and the shared adder datapath; no two operations are ever in flight at once.

---
 rtl/adder_arb_pkg.sv | 18 +
 rtl/adder_arbiter_rr.sv | 37 +++
 rtl/adder_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and width helpers for the round-robin adder arbiter.
package adder_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Requester-id width: at least one bit even for tiny requester counts.
  function automatic int calc_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = adder_arb_pkg::calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  int   idx;
  logic found;

  // Scan upward from ptr; the first hit wins and later hits are ignored.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NREQ) begin
          idx = idx - NREQ;
        end
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = IDW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among NREQ requesters; one operation in flight at a time.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SWIDTH = WIDTH + 1,
  parameter int IDW    = calc_idw(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [SWIDTH-1:0]     rsp_sum,
  output logic                  rsp_zero,
  output logic                  busy
);

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               cin_q, cin_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [SWIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;

  logic [WIDTH-1:0]   x_arr [NREQ];
  logic [WIDTH-1:0]   y_arr [NREQ];
  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_id;
  logic               arb_en;
  logic [SWIDTH-1:0]  sum;

  // Unpack per-requester operand slices so the winner can be selected by id.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign x_arr[gi] = req_x[gi*WIDTH +: WIDTH];
    assign y_arr[gi] = req_y[gi*WIDTH +: WIDTH];
  end

  // Grants only in IDLE; a reset in the grant cycle suppresses the handshake
  // so the requester does not believe it was served.
  assign arb_en = (state_q == ST_IDLE) && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Full-width sum keeps the carry-out.
  assign sum = SWIDTH'(x_q) + SWIDTH'(y_q) + SWIDTH'(cin_q);

  // Next-state and datapath capture for the IDLE/CALC/RESP sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    x_d         = x_q;
    y_d         = y_q;
    cin_d       = cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          x_d     = x_arr[gnt_id];
          y_d     = y_arr[gnt_id];
          cin_d   = req_cin[gnt_id];
          id_d    = gnt_id;
          ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        rsp_sum_d   = sum;
        rsp_zero_d  = (sum == '0);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cin_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cin_q       <= cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
